// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone classic slave driving an asynchronous 32-bit SRAM pair with programmable wait states.
module wb_sram_ctrl #(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic        clk_50mhz,
  input  logic        reset,
  input  logic [17:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [17:0] sram_addr_o,
  output logic [31:0] sram_dat_o,
  input  logic [31:0] sram_dat_i,
  output logic        sram_cs_o,
  output logic        sram_oe_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_bsel_o
);
  typedef enum logic [2:0] {IDLE, READ, WSETUP, WRITE, WHOLD, ACK} state_t;
  localparam logic [3:0] RW1 = 4'(READ_WAIT - 1);
  localparam logic [3:0] WW1 = 4'(WRITE_WAIT - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic ack_n, cs_n, oe_n, we_n;
  logic [3:0] bsel_n;
  logic [17:0] addr_n;
  logic [31:0] sdat_n, rdat_n;
  logic req;
  assign req = wb_cyc_i & wb_stb_i;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ack_n = 1'b0;
    cs_n = sram_cs_o;
    oe_n = sram_oe_o;
    we_n = sram_we_o;
    bsel_n = sram_bsel_o;
    addr_n = sram_addr_o;
    sdat_n = sram_dat_o;
    rdat_n = wb_dat_o;
    case (state)
      IDLE: if (req) begin
        if (wb_sel_i == 4'b0) begin
          ack_n = 1'b1;
          state_n = ACK;
        end else begin
          addr_n = wb_adr_i;
          bsel_n = wb_sel_i;
          cs_n = 1'b1;
          if (wb_we_i) begin
            sdat_n = wb_dat_i;
            state_n = WSETUP;
          end else begin
            oe_n = 1'b1;
            cnt_n = RW1;
            state_n = READ;
          end
        end
      end
      READ: if (cnt != 4'd0) cnt_n = cnt - 4'd1;
      else begin
        rdat_n = sram_dat_i;
        cs_n = 1'b0;
        oe_n = 1'b0;
        bsel_n = 4'b0;
        ack_n = req;
        state_n = ACK;
      end
      WSETUP: begin
        we_n = 1'b1;
        cnt_n = WW1;
        state_n = WRITE;
      end
      WRITE: if (cnt != 4'd0) cnt_n = cnt - 4'd1;
      else begin
        we_n = 1'b0;
        state_n = WHOLD;
      end
      WHOLD: begin
        cs_n = 1'b0;
        bsel_n = 4'b0;
        ack_n = req;
        state_n = ACK;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_50mhz) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      wb_ack_o <= 1'b0;
      sram_cs_o <= 1'b0;
      sram_oe_o <= 1'b0;
      sram_we_o <= 1'b0;
      sram_bsel_o <= 4'b0;
      sram_addr_o <= 18'b0;
      sram_dat_o <= 32'b0;
      wb_dat_o <= 32'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wb_ack_o <= ack_n;
      sram_cs_o <= cs_n;
      sram_oe_o <= oe_n;
      sram_we_o <= we_n;
      sram_bsel_o <= bsel_n;
      sram_addr_o <= addr_n;
      sram_dat_o <= sdat_n;
      wb_dat_o <= rdat_n;
    end
  end
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb_wb_sram_ctrl: vector table plus scoreboard bench for wb_sram_ctrl, with a behavioural SRAM model.
module tb_wb_sram_ctrl;
  localparam int RW = 1;
  localparam int WW = 2;
  logic clk_50mhz = 1'b0;
  logic reset = 1'b0;
  logic [17:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0] wb_sel_i = '0;
  logic wb_we_i = 1'b0;
  logic wb_cyc_i = 1'b0;
  logic wb_stb_i = 1'b0;
  logic wb_ack_o;
  logic [17:0] sram_addr_o;
  logic [31:0] sram_dat_o;
  logic [31:0] sram_dat_i = '0;
  logic sram_cs_o, sram_oe_o, sram_we_o;
  logic [3:0] sram_bsel_o;

  wb_sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk_50mhz(clk_50mhz), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .sram_addr_o(sram_addr_o), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
    .sram_cs_o(sram_cs_o), .sram_oe_o(sram_oe_o), .sram_we_o(sram_we_o),
    .sram_bsel_o(sram_bsel_o)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  always @(posedge clk_50mhz) cyc_n <= cyc_n + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM model: byte-lane writes on every edge with cs&we, read data presented mid-cycle
  logic [31:0] mem [logic [17:0]];
  logic [31:0] wtmp;
  function automatic logic [31:0] rd(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction
  always @(posedge clk_50mhz) if (sram_cs_o && sram_we_o) begin
    wtmp = rd(sram_addr_o);
    for (int b = 0; b < 4; b++) if (sram_bsel_o[b]) wtmp[8*b +: 8] = sram_dat_o[8*b +: 8];
    mem[sram_addr_o] = wtmp;
  end
  always @(negedge clk_50mhz) sram_dat_i = (sram_cs_o && sram_oe_o) ? rd(sram_addr_o) : 32'h0;

  typedef struct { logic [31:0] dat; int at; } exp_t;
  exp_t sb[$];

  logic pcs = 1'b0;
  logic [17:0] pa = '0;
  logic [3:0] pb = '0;
  logic [31:0] pd = '0;
  always @(negedge clk_50mhz) begin
    exp_t e;
    if (reset) begin
      if (pcs && sram_cs_o) begin
        chk({sram_addr_o, sram_bsel_o} == {pa, pb}, "addr_bsel_stable", {10'b0, sram_addr_o, sram_bsel_o}, {10'b0, pa, pb});
        chk(sram_dat_o == pd, "dat_stable", sram_dat_o, pd);
        chk(!(sram_we_o && sram_oe_o), "we_oe_excl", {30'b0, sram_we_o, sram_oe_o}, 32'h0);
      end
      if (wb_ack_o) begin
        if (sb.size() == 0) chk(1'b0, "unexpected_ack", 32'h1, 32'h0);
        else begin
          e = sb.pop_front();
          chk(wb_dat_o == e.dat, "ack_rdata", wb_dat_o, e.dat);
          chk(cyc_n == e.at, "ack_cycle", cyc_n, e.at);
        end
      end
    end
    pcs = sram_cs_o;
    pa = sram_addr_o;
    pb = sram_bsel_o;
    pd = sram_dat_o;
  end

  typedef struct { logic we; logic [17:0] adr; logic [31:0] dat; logic [3:0] sel; logic [31:0] exp; } vec_t;
  vec_t vecs[10];

  task automatic chk_zero(input string name);
    chk({wb_ack_o, sram_cs_o, sram_oe_o, sram_we_o, sram_bsel_o} == 8'h0, {name, "_ctl"},
        {24'b0, wb_ack_o, sram_cs_o, sram_oe_o, sram_we_o, sram_bsel_o}, 32'h0);
    chk(sram_addr_o == 18'h0, {name, "_addr"}, {14'b0, sram_addr_o}, 32'h0);
    chk(sram_dat_o == 32'h0, {name, "_sdat"}, sram_dat_o, 32'h0);
    chk(wb_dat_o == 32'h0, {name, "_rdat"}, wb_dat_o, 32'h0);
  endtask

  task automatic drive(input vec_t v);
    int lat;
    bit saw_cs;
    lat = (v.sel == 4'b0) ? 1 : (v.we ? WW + 3 : RW + 1);
    wb_adr_i = v.adr; wb_dat_i = v.dat; wb_sel_i = v.sel; wb_we_i = v.we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    sb.push_back('{v.exp, cyc_n + lat});
    saw_cs = 1'b0;
    for (int n = 0; n < 40 && !wb_ack_o; n++) begin
      @(negedge clk_50mhz);
      saw_cs |= sram_cs_o;
    end
    if (!wb_ack_o) chk(1'b0, "ack_timeout", 32'h0, 32'h1);
    if (v.sel == 4'b0) chk(!saw_cs, "sel0_no_cs", {31'b0, saw_cs}, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk_50mhz);
  endtask

  task automatic write_wave(input logic [17:0] a, input logic [31:0] d, input logic [3:0] s, input logic [31:0] rexp);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    sb.push_back('{rexp, cyc_n + WW + 3});
    @(negedge clk_50mhz);
    chk({sram_cs_o, sram_oe_o, sram_we_o} == 3'b100, "wr_setup_ctl", {29'b0, sram_cs_o, sram_oe_o, sram_we_o}, 32'h4);
    chk(sram_addr_o == a, "wr_addr", {14'b0, sram_addr_o}, {14'b0, a});
    chk(sram_bsel_o == s, "wr_bsel", {28'b0, sram_bsel_o}, {28'b0, s});
    chk(sram_dat_o == d, "wr_dat", sram_dat_o, d);
    for (int k = 0; k < WW; k++) begin
      @(negedge clk_50mhz);
      chk({sram_cs_o, sram_oe_o, sram_we_o} == 3'b101, "wr_pulse_ctl", {29'b0, sram_cs_o, sram_oe_o, sram_we_o}, 32'h5);
    end
    @(negedge clk_50mhz);
    chk({sram_cs_o, sram_oe_o, sram_we_o} == 3'b100, "wr_hold_ctl", {29'b0, sram_cs_o, sram_oe_o, sram_we_o}, 32'h4);
    chk(sram_dat_o == d && sram_bsel_o == s, "wr_hold_data", sram_dat_o, d);
    @(negedge clk_50mhz);
    chk({wb_ack_o, sram_cs_o, sram_bsel_o} == 6'b100000, "wr_ack_ctl", {26'b0, wb_ack_o, sram_cs_o, sram_bsel_o}, 32'h20);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk_50mhz);
  endtask

  initial begin
    int wecnt, ackcnt;
    vecs[0] = '{1'b0, 18'h12345, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 18'h3FFFF, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 18'h3FFFF, 32'h0,        4'hF, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 18'h3FFFF, 32'h00AB0000, 4'h4, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 18'h3FFFF, 32'h0,        4'h1, 32'hCAABF00D};
    vecs[5] = '{1'b0, 18'h00000, 32'h0,        4'h0, 32'hCAABF00D};
    vecs[6] = '{1'b1, 18'h00000, 32'h11223344, 4'h0, 32'hCAABF00D};
    vecs[7] = '{1'b0, 18'h00000, 32'h0,        4'hF, 32'h00000000};
    vecs[8] = '{1'b1, 18'h00001, 32'hA5A5A5A5, 4'h9, 32'h00000000};
    vecs[9] = '{1'b0, 18'h00001, 32'h0,        4'hF, 32'hA50000A5};
    mem[18'h12345] = 32'hDEADBEEF;
    repeat (3) @(negedge clk_50mhz);
    chk_zero("reset_init");
    reset = 1'b1;
    @(negedge clk_50mhz);
    for (int i = 0; i < 10; i++) drive(vecs[i]);
    write_wave(18'h3FFFF, 32'hCAFEF00D, 4'hF, 32'hA50000A5);
    write_wave(18'h00200, 32'h00AB0000, 4'h4, 32'hA50000A5);
    drive('{1'b0, 18'h00200, 32'h0, 4'hF, 32'h00AB0000});
    // abort a write mid-pulse: the pin sequence must finish, with no ack
    wb_adr_i = 18'h00100; wb_dat_i = 32'h12345678; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (2) @(negedge clk_50mhz);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wecnt = sram_we_o ? 1 : 0;
    ackcnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_50mhz);
      wecnt += sram_we_o ? 1 : 0;
      ackcnt += wb_ack_o ? 1 : 0;
    end
    chk(wecnt == WW, "abort_we_cycles", wecnt, WW);
    chk(ackcnt == 0, "abort_no_ack", ackcnt, 0);
    chk(sram_cs_o == 1'b0, "abort_cs_idle", {31'b0, sram_cs_o}, 32'h0);
    chk(rd(18'h00100) == 32'h12345678, "abort_mem", rd(18'h00100), 32'h12345678);
    drive('{1'b0, 18'h00100, 32'h0, 4'hF, 32'h12345678});
    // reset in the middle of a read
    wb_adr_i = 18'h12345; wb_sel_i = 4'hF; wb_we_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge clk_50mhz);
    chk(sram_cs_o && sram_oe_o, "rd_active", {30'b0, sram_cs_o, sram_oe_o}, 32'h3);
    reset = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    chk_zero("reset_mid");
    reset = 1'b1;
    @(negedge clk_50mhz);
    drive('{1'b0, 18'h12345, 32'h0, 4'hF, 32'hDEADBEEF});
    repeat (3) @(negedge clk_50mhz);
    chk(sb.size() == 0, "sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
- Wishbone classic slave that runs the external asynchronous SRAM pair as one 32-bit memory (256K words, 1 MB).
- Sits inside m68k_computer, between the system Wishbone interconnect and the sram_* signal set.
- The top level turns that signal set into pins: active-low cen/ubn/lbn/oen/wen and tri-state data.
- Generates the strobe sequence, wait states, byte enables and write data, and captures read data.

Parameters:
READ_WAIT, 1, clock cycles with sram_oe_o asserted before read data is captured (1..15)
WRITE_WAIT, 1, clock cycles sram_we_o is asserted per write (1..15)

Ports:
clk_50mhz  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset
wb_adr_i  input  18  word address; the interconnect connects byte address bits [19:2]
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data, registered
wb_sel_i  input  4  byte selects; bit3 = bits 31:24
wb_we_i  input  1  1 = write
wb_cyc_i  input  1  bus cycle
wb_stb_i  input  1  strobe
wb_ack_o  output  1  acknowledge, single-cycle pulse
sram_addr_o  output  18  SRAM word address
sram_dat_o  output  32  SRAM write data
sram_dat_i  input  32  SRAM read data
sram_cs_o  output  1  chip select, active-high
sram_oe_o  output  1  output enable, active-high
sram_we_o  output  1  write enable, active-high
sram_bsel_o  output  4  byte lane enables, active-high

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clock edge), effective at that edge, including mid-access:
  - state=IDLE
  - wb_ack_o, sram_cs_o, sram_oe_o, sram_we_o = 0
  - sram_bsel_o = 0, sram_addr_o = 0, sram_dat_o = 0, wb_dat_o = 0, wait counter = 0
- States: IDLE, READ, WSETUP, WRITE, WHOLD, ACK.
- IDLE, request = wb_cyc_i & wb_stb_i:
  - wb_sel_i==0: go to ACK with no SRAM activity.
  - Read: latch wb_adr_i/wb_sel_i into sram_addr_o/sram_bsel_o; set cs=1, oe=1; counter=READ_WAIT-1; go to READ.
  - Write: latch address, sel, and wb_dat_i into sram_dat_o; set cs=1, we=0; go to WSETUP.
- READ:
  - While counter!=0, decrement.
  - When counter==0, at the edge: wb_dat_o<=sram_dat_i (all 32 bits); cs=0, oe=0, bsel=0; go to ACK.
- WSETUP: one cycle (address and data setup). Then we=1, counter=WRITE_WAIT-1; go to WRITE.
- WRITE:
  - Decrement counter.
  - When counter==0: we=0; go to WHOLD.
- WHOLD: one cycle with cs, addr, bsel and dat held and we=0 (hold time). Then cs=0, bsel=0; go to ACK.
- ACK:
  - wb_ack_o=1 for exactly this cycle, only if wb_cyc_i & wb_stb_i are still high; otherwise wb_ack_o stays 0.
  - Always go to IDLE. The request is not sampled in ACK, so a master still holding stb does not retrigger.
- Latency from the cycle stb is first seen in IDLE (cycle 0):
  - Read: ack in cycle READ_WAIT+1.
  - Write: ack in cycle WRITE_WAIT+3.
  - Back-to-back requests: one IDLE cycle minimum between the ack and the next access start.
- Abort: if cyc/stb drop mid-access, the SRAM access still completes its full pin sequence (no truncated write pulse), and no ack is issued.
- Invariants:
  - we and oe are never 1 together.
  - we only rises one or more cycles after cs, address and bsel are stable.
  - Address, bsel and dat_o never change while cs=1.
- wb_dat_o holds its last captured value; it is not cleared on writes.

Test Plan:
1. Reset held low 3 cycles, including during an active read -> every output reads 0 on the edge after reset, state returns to IDLE, no ack.
2. READ_WAIT=1: read adr=0x12345, sel=1111, sram_dat_i=0xDEADBEEF -> cycle1 cs=1 oe=1 addr=0x12345 bsel=1111; cycle2 ack=1, wb_dat_o=0xDEADBEEF, cs=0.
3. WRITE_WAIT=2: write adr=0x3FFFF, dat=0xCAFEF00D, sel=1111 -> cycle1 cs=1 we=0; cycles2-3 we=1; cycle4 we=0 cs=1 with data held; cycle5 ack, cs=0; sram_dat_o=0xCAFEF00D throughout.
4. Byte write sel=0100, dat=0x00AB0000 -> bsel=0100 for the entire access, ack after 4 cycles (WRITE_WAIT=1).
5. Request with sel=0000 -> ack in cycle 1, sram_cs_o never asserted.
6. Write with stb/cyc dropped during the WRITE state -> full we pulse and WHOLD still occur, wb_ack_o stays 0, returns to IDLE, and the next read proceeds normally.
